multi_channel_buffer: RTL and testbench
=======================================

MULTI_CHANNEL_BUFFER -- requirements
Module: multi_channel_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent input channels (2..16).
REQ-002 SHALL have parameter BUFFER_DEPTH, default 8, entries per channel (2..256, power of two not required).
REQ-003 SHALL have parameter BUFFER_WIDTH, default 64, payload bits per entry.
REQ-004 SHALL have parameter AFULL_TH, default BUFFER_DEPTH-2, per-channel almost-full occupancy threshold.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in  input  NUM_CH*BUFFER_WIDTH  per-channel write data; channel c at bits [c*BUFFER_WIDTH +: BUFFER_WIDTH].
REQ-008 SHALL have port produce  input  NUM_CH  per-channel write strobe.
REQ-009 SHALL have port full  output  NUM_CH  per-channel full flag.
REQ-010 SHALL have port almost_full  output  NUM_CH  per-channel occupancy >= AFULL_TH.
REQ-011 SHALL have port count  output  NUM_CH*CNT_W  per-channel occupancy, CNT_W = $clog2(BUFFER_DEPTH+1).
REQ-012 SHALL have port out  output  BUFFER_WIDTH  registered read data.
REQ-013 SHALL have port out_ch  output  max(1,$clog2(NUM_CH))  source channel of out.
REQ-014 SHALL have port out_valid  output  1  out/out_ch hold a valid entry.
REQ-015 SHALL have port out_ready  input  1  downstream accepts out this cycle.

Function
REQ-016 Each channel SHALL hold BUFFER_DEPTH entries (full capacity, no sacrificed slot); head/tail pointers wrap from BUFFER_DEPTH-1 to 0.
REQ-017 full[c] SHALL be 1 exactly when count[c]==BUFFER_DEPTH; empty is internal, count[c]==0.
REQ-018 produce[c] with full[c]==0 SHALL write in[c] at tail and increment count[c]; produce[c] with full[c]==1 SHALL be dropped, no state change, even if the same channel is popped that cycle.
REQ-019 Output stage SHALL be a one-entry register; it loads when out_valid==0 or (out_valid && out_ready).
REQ-020 On load, arbiter SHALL grant the first non-empty channel in round-robin order starting at (last_grant+1) mod NUM_CH, pop its head, and set out, out_ch, out_valid=1.
REQ-021 If load is permitted and all channels empty, out_valid SHALL go to 0; out holds its previous value.
REQ-022 While out_valid && !out_ready, out/out_ch SHALL hold stable and no channel is popped.
REQ-023 Push and pop on the same channel in one cycle SHALL leave count unchanged and both proceed (non-full case).
REQ-024 Latency: entry written at edge E SHALL be visible on out no earlier than after edge E+1 (no combinational in-to-out bypass).
REQ-025 Sustained throughput SHALL be one entry per cycle when out_ready stays 1 and any channel is non-empty.
REQ-026 Arbitration SHALL be starvation-free: a non-empty channel is granted within NUM_CH loads.

Reset
REQ-027 rst==0 SHALL asynchronously clear all pointers, count, full=0, almost_full=(AFULL_TH==0), out_valid=0, out=0, out_ch=0, last_grant=NUM_CH-1.
REQ-028 Storage arrays SHALL NOT be reset; reset mid-operation discards all buffered and in-flight entries.
REQ-029 Deassertion SHALL be treated synchronously by the integrator; the first active edge after release may accept produce.

Configuration
REQ-030 With macro MULTI_CHANNEL_BUFFER_DROP_CNT_EN defined, SHALL add output drop_cnt (NUM_CH*16) counting dropped produce per channel, saturating at 16'hFFFF, cleared by rst.
REQ-031 Without MULTI_CHANNEL_BUFFER_DROP_CNT_EN, port drop_cnt and its counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, push ch0 D=0xA1 once, out_ready=1 -> out_valid rises after 2nd edge, out=0xA1, out_ch=0, then out_valid=0.
REQ-033 DEPTH=8: push ch2 nine times with out_ready=0 -> full[2]=1 after 8th push, count[2]=8, 9th dropped (drop_cnt[2]=1 with macro), drain yields 8 entries in order.
REQ-034 All 4 channels preloaded 3 entries, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycles.
REQ-035 out_ready=0 for 5 cycles while out_valid=1 -> out/out_ch unchanged, counts unchanged apart from pushes.
REQ-036 Full ch1 with simultaneous produce[1] and pop of ch1 -> push dropped, count[1] becomes 7.
REQ-037 Assert rst low mid-stream with 5 entries buffered -> immediately out_valid=0, count=0, full=0; post-release push returns single correct entry.

Source files
------------

// File: rtl/multi_channel_buffer_if.sv
// Bundles the per-channel write side and the single read side of multi_channel_buffer.
// drop_cnt is present only when MULTI_CHANNEL_BUFFER_DROP_CNT_EN is defined.
interface multi_channel_buffer_if #(
   parameter int NUM_CH       = 4,
   parameter int BUFFER_DEPTH = 8,
   parameter int BUFFER_WIDTH = 64
);
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*BUFFER_WIDTH-1:0] in;
   logic [NUM_CH-1:0]              produce;
   logic [NUM_CH-1:0]              full;
   logic [NUM_CH-1:0]              almost_full;
   logic [NUM_CH*CNT_W-1:0]        count;
   logic [BUFFER_WIDTH-1:0]        out;
   logic [CH_W-1:0]                out_ch;
   logic                           out_valid;
   logic                           out_ready;
`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
   logic [NUM_CH*16-1:0]           drop_cnt;
`endif

   modport master (
      output in, produce, out_ready,
`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
      input  drop_cnt,
`endif
      input  full, almost_full, count, out, out_ch, out_valid
   );

   modport slave (
      input  in, produce, out_ready,
`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
      output drop_cnt,
`endif
      output full, almost_full, count, out, out_ch, out_valid
   );
endinterface

// File: rtl/multi_channel_buffer.sv
// NUM_CH independent FIFOs drained through one registered output stage by a round-robin arbiter.
// Optional per-channel saturating drop counters: define MULTI_CHANNEL_BUFFER_DROP_CNT_EN.
module multi_channel_buffer #(
   parameter int NUM_CH       = 4,
   parameter int BUFFER_DEPTH = 8,
   parameter int BUFFER_WIDTH = 64,
   parameter int AFULL_TH     = BUFFER_DEPTH - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   multi_channel_buffer_if.slave bus
);
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   logic [NUM_CH-1:0]       w_empty;
   logic [NUM_CH-1:0]       w_full;
   logic [NUM_CH-1:0]       w_push;
   logic [NUM_CH-1:0]       w_pop;
   logic [BUFFER_WIDTH-1:0] w_head_data [NUM_CH];
   logic                    w_load;
   logic                    w_found;
   logic [CH_W-1:0]         w_grant;
   logic [CH_W-1:0]         w_cand;

   logic [BUFFER_WIDTH-1:0] r_out;
   logic [CH_W-1:0]         r_out_ch;
   logic                    r_out_valid;
   logic [CH_W-1:0]         r_last_grant;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [BUFFER_WIDTH-1:0] r_mem [BUFFER_DEPTH];
      logic [PTR_W-1:0]        r_head;
      logic [PTR_W-1:0]        r_tail;
      logic [CNT_W-1:0]        r_count;

      assign w_empty[c]     = (r_count == '0);
      assign w_full[c]      = (r_count == CNT_FULL);
      // A full channel drops its write even if it is popped on the same edge.
      assign w_push[c]      = bus.produce[c] && !w_full[c];
      assign w_pop[c]       = w_load && w_found && (w_grant == CH_W'(c));
      assign w_head_data[c] = r_mem[r_head];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push[c]) r_tail <= ptr_inc(r_tail);
            if (w_pop[c])  r_head <= ptr_inc(r_head);
            case ({w_push[c], w_pop[c]})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end

      // NOTE: storage has no reset; valid data is tracked by the pointers and count,
      // so clearing the array would only add reset fan-out to every bit.
      always_ff @(posedge clk) begin
         if (w_push[c]) r_mem[r_tail] <= bus.in[c*BUFFER_WIDTH +: BUFFER_WIDTH];
      end

      assign bus.full[c]                    = w_full[c];
      assign bus.almost_full[c]             = (int'(r_count) >= AFULL_TH);
      assign bus.count[c*CNT_W +: CNT_W]    = r_count;

`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
      logic [15:0] r_drop_cnt;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_drop_cnt <= '0;
         end else if (bus.produce[c] && w_full[c] && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end

      assign bus.drop_cnt[c*16 +: 16] = r_drop_cnt;
`endif
   end

   assign w_load = !r_out_valid || bus.out_ready;

   // Scan starts one past the last grant, so every non-empty channel wins within NUM_CH loads.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_found = 1'b0;
      w_grant = '0;
      w_cand  = r_last_grant;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cand = (w_cand == CH_LAST) ? '0 : w_cand + CH_W'(1);
         if (!w_found && !w_empty[w_cand]) begin
            w_found = 1'b1;
            w_grant = w_cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out        <= '0;
         r_out_ch     <= '0;
         r_out_valid  <= 1'b0;
         r_last_grant <= CH_LAST;
      end else if (w_load) begin
         if (w_found) begin
            r_out        <= w_head_data[w_grant];
            r_out_ch     <= w_grant;
            r_out_valid  <= 1'b1;
            r_last_grant <= w_grant;
         end else begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_multi_channel_buffer.sv
// Directed bench for multi_channel_buffer with a queue-based reference model checked every cycle.
// Drop-counter checks are compiled in with MULTI_CHANNEL_BUFFER_DROP_CNT_EN.
module tb_multi_channel_buffer;
   localparam int NUM_CH   = 4;
   localparam int DEPTH    = 8;
   localparam int W        = 64;
   localparam int AFULL_TH = DEPTH - 2;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   multi_channel_buffer_if #(.NUM_CH(NUM_CH), .BUFFER_DEPTH(DEPTH), .BUFFER_WIDTH(W)) bus ();

   multi_channel_buffer #(
      .NUM_CH(NUM_CH), .BUFFER_DEPTH(DEPTH), .BUFFER_WIDTH(W), .AFULL_TH(AFULL_TH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per channel plus the output register contents.
   logic [W-1:0] m_q [NUM_CH][$];
   bit           m_was_full [NUM_CH];
   bit           m_valid;
   logic [W-1:0] m_out;
   int           m_ch;
   int           m_last;
   int           m_g;
   int           m_c;
   int           m_drop [NUM_CH];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_q[c].delete();
            m_drop[c] = 0;
         end
         m_valid = 1'b0;
         m_out   = '0;
         m_ch    = 0;
         m_last  = NUM_CH - 1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) m_was_full[c] = (m_q[c].size() == DEPTH);
         if (!m_valid || bus.out_ready) begin
            m_g = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
               m_c = (m_last + k) % NUM_CH;
               if (m_g < 0 && m_q[m_c].size() > 0) m_g = m_c;
            end
            if (m_g >= 0) begin
               m_out   = m_q[m_g].pop_front();
               m_ch    = m_g;
               m_valid = 1'b1;
               m_last  = m_g;
            end else begin
               m_valid = 1'b0;
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.produce[c]) begin
               if (m_was_full[c]) begin
                  if (m_drop[c] < 16'hFFFF) m_drop[c]++;
               end else begin
                  m_q[c].push_back(bus.in[c*W +: W]);
               end
            end
         end
      end
   end

   logic [NUM_CH*CNT_W-1:0] e_count;
   logic [NUM_CH-1:0]       e_full;
   logic [NUM_CH-1:0]       e_af;
   logic [NUM_CH*16-1:0]    e_drop;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         for (int c = 0; c < NUM_CH; c++) begin
            e_count[c*CNT_W +: CNT_W] = CNT_W'(m_q[c].size());
            e_full[c]                 = (m_q[c].size() == DEPTH);
            e_af[c]                   = (m_q[c].size() >= AFULL_TH);
            e_drop[c*16 +: 16]        = 16'(m_drop[c]);
         end
         check("model out_valid", 64'(bus.out_valid), 64'(m_valid));
         check("model out", bus.out, m_out);
         if (m_valid) check("model out_ch", 64'(bus.out_ch), 64'(m_ch));
         check("model count", 64'(bus.count), 64'(e_count));
         check("model full", 64'(bus.full), 64'(e_full));
         check("model almost_full", 64'(bus.almost_full), 64'(e_af));
`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
         check("model drop_cnt", 64'(bus.drop_cnt), 64'(e_drop));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [W-1:0] d);
      bus.produce[c]  = 1'b1;
      bus.in[c*W +: W] = d;
   endtask

   task automatic idle();
      bus.produce = '0;
   endtask

   // Called 1 time unit after a rising edge; released well before the next edge.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst out", bus.out, 64'd0);
      check("rst out_ch", 64'(bus.out_ch), 64'd0);
      check("rst count", 64'(bus.count), 64'd0);
      check("rst full", 64'(bus.full), 64'd0);
      check("rst almost_full", 64'(bus.almost_full), 64'd0);
      #2;
      rst = 1'b1;
   endtask

   logic [W-1:0] hold_out;

   initial begin
      rst           = 1'b0;
      bus.in        = '0;
      bus.produce   = '0;
      bus.out_ready = 1'b0;
      step();
      do_reset();

      // Single entry on ch0: visible after the second edge, then idle.
      bus.out_ready = 1'b1;
      push(0, 64'hA1);
      step();
      idle();
      check("single not yet valid", 64'(bus.out_valid), 64'd0);
      step();
      check("single valid", 64'(bus.out_valid), 64'd1);
      check("single out", bus.out, 64'hA1);
      check("single out_ch", 64'(bus.out_ch), 64'd0);
      step();
      check("single drained", 64'(bus.out_valid), 64'd0);

      // Park one entry in the output register, then fill ch2 to capacity and overflow.
      bus.out_ready = 1'b0;
      push(0, 64'h55);
      step();
      idle();
      step();
      check("park valid", 64'(bus.out_valid), 64'd1);
      for (int k = 0; k < 9; k++) begin
         push(2, 64'h200 + 64'(k));
         step();
         if (k == 4) check("ch2 af below th", 64'(bus.almost_full[2]), 64'd0);
         if (k == 5) check("ch2 af at th", 64'(bus.almost_full[2]), 64'd1);
         if (k == 6) check("ch2 not full at 7", 64'(bus.full[2]), 64'd0);
         if (k >= 7) begin
            check("ch2 full", 64'(bus.full[2]), 64'd1);
            check("ch2 count 8", 64'(bus.count[2*CNT_W +: CNT_W]), 64'd8);
         end
      end
      idle();
`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
      check("ch2 drop_cnt", 64'(bus.drop_cnt[2*16 +: 16]), 64'd1);
`endif
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         check("ch2 drain ch", 64'(bus.out_ch), 64'd2);
         check("ch2 drain data", bus.out, 64'h200 + 64'(k));
      end
      step();
      check("ch2 drained", 64'(bus.out_valid), 64'd0);

      // Three entries per channel, a five-cycle stall, then full-rate round robin.
      step();
      do_reset();
      bus.out_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < NUM_CH; c++) push(c, 64'hC0DE_0000 + 64'(c*16 + r));
         step();
      end
      idle();
      check("preload count", 64'(bus.count), 64'h3332);
      check("preload out", bus.out, 64'hC0DE_0000);
      hold_out = bus.out;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall out", bus.out, hold_out);
         check("stall out_ch", 64'(bus.out_ch), 64'd0);
         check("stall count", 64'(bus.count), 64'h3332);
      end
      bus.out_ready = 1'b1;
      for (int i = 1; i < 12; i++) begin
         step();
         check("rr valid", 64'(bus.out_valid), 64'd1);
         check("rr out_ch", 64'(bus.out_ch), 64'(i % 4));
         check("rr data", bus.out, 64'hC0DE_0000 + 64'((i % 4)*16 + i / 4));
      end
      step();
      check("rr drained", 64'(bus.out_valid), 64'd0);

      // Full ch1 written while being popped: the write is dropped.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         push(1, 64'h100 + 64'(k));
         step();
      end
      check("ch1 full", 64'(bus.full[1]), 64'd1);
      push(1, 64'h1FF);
      bus.out_ready = 1'b1;
      step();
      idle();
      check("ch1 count 7", 64'(bus.count), 64'h0070);
      check("ch1 next out", bus.out, 64'h101);
`ifdef MULTI_CHANNEL_BUFFER_DROP_CNT_EN
      check("ch1 drop_cnt", 64'(bus.drop_cnt[1*16 +: 16]), 64'd1);
`endif
      for (int k = 0; k < 8; k++) step();
      check("ch1 drained", 64'(bus.out_valid), 64'd0);

      // Reset with five entries buffered, then one clean transfer.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         push(3, 64'h300 + 64'(k));
         step();
      end
      idle();
      check("ch3 count 5", 64'(bus.count), 64'h5000);
      do_reset();
      bus.out_ready = 1'b1;
      push(3, 64'hBEEF);
      step();
      idle();
      check("post-rst not yet valid", 64'(bus.out_valid), 64'd0);
      step();
      check("post-rst valid", 64'(bus.out_valid), 64'd1);
      check("post-rst out", bus.out, 64'hBEEF);
      check("post-rst out_ch", 64'(bus.out_ch), 64'd3);
      step();
      check("post-rst drained", 64'(bus.out_valid), 64'd0);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
